inst_mem_loader: RTL and testbench

- Byte-addressed, big-endian instruction memory with a fetch port and a streaming byte loader (valid/ready).
- The loader is fed by the debug unit, e.g. a UART byte stream, and fills the memory from address 0 through a small FSM.
- Successor to the per-word debug-write instruction memory: parametrised width and depth, single clock edge, alignment and range checking, explicit load completion and error reporting.
- Sits between the PC/IF stage and the debug unit.

---
 rtl/inst_mem_pkg.sv | 33 +++
 rtl/inst_mem_load_fsm.sv | 94 +++++++++
 rtl/inst_mem_loader.sv | 105 ++++++++++
 tb/tb_inst_mem_loader.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/inst_mem_pkg.sv
// Shared types, default sizing and the address range/alignment check used by
// both the fetch path and the debug readback path of the instruction memory.
package inst_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_NB_BYTE = 8;
  localparam int DEF_NB_INST = 32;
  localparam int DEF_DEPTH   = 1024;
  localparam int DEF_NB_ADDR = 32;

  localparam int BYTES       = DEF_NB_INST / DEF_NB_BYTE;
  localparam int NB_MEM_ADDR = $clog2(DEF_DEPTH);
  localparam int NOP         = 0;

  // True when a full word starting at addr lies inside memory, and (if
  // requested) addr sits on a word boundary.
  function automatic logic f_addr_ok(input logic [DEF_NB_ADDR-1:0] addr,
                                     input logic                   align_check,
                                     input int unsigned            bytes,
                                     input int unsigned            depth);
    logic [DEF_NB_ADDR-1:0] lim;
    logic                   aligned;
    lim     = DEF_NB_ADDR'(depth - bytes);
    aligned = ((addr % DEF_NB_ADDR'(bytes)) == '0);
    return (addr <= lim) && (!align_check || aligned);
  endfunction

endpackage

// File: rtl/inst_mem_load_fsm.sv
// Streaming byte loader: validates the requested length, accepts bytes over a
// valid/ready handshake and emits the memory write strobe and byte address.
//
//   state   | meaning
//   --------+--------------------------------------------------
//   ST_IDLE | waiting for i_ld_start; bad lengths pulse o_ld_err
//   ST_LOAD | ready high, one byte written per valid cycle
//   ST_DONE | single-cycle o_ld_done, then back to idle
module inst_mem_load_fsm
  import inst_mem_pkg::*;
#(
  parameter int NB_ADDR     = 32,
  parameter int N_BYTES     = 4,
  parameter int DEPTH       = 1024,
  parameter int MEM_AW      = 10
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_ld_start,
  input  logic [NB_ADDR-1:0] i_ld_len,
  input  logic               i_ld_valid,
  output logic               o_ld_ready,
  output logic               o_ld_busy,
  output logic               o_ld_done,
  output logic               o_ld_err,
  output logic [NB_ADDR-1:0] o_ld_count,
  output logic               o_we,
  output logic [MEM_AW-1:0]  o_waddr
);

  state_t             state_q, state_d;
  logic [NB_ADDR-1:0] len_q, len_d;
  logic [NB_ADDR-1:0] count_q, count_d;
  logic               err_q, err_d;
  logic               len_ok;
  logic               accept;

  assign len_ok = (i_ld_len != '0) &&
                  ((i_ld_len % NB_ADDR'(N_BYTES)) == '0) &&
                  (i_ld_len <= NB_ADDR'(DEPTH));
  assign accept = (state_q == ST_LOAD) && i_ld_valid;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    count_d = count_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_ld_start) begin
          if (len_ok) begin
            len_d   = i_ld_len;
            count_d = '0;
            state_d = ST_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (accept) begin
          count_d = count_q + 1'b1;
          if (count_q == len_q - 1'b1) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign o_ld_ready = (state_q == ST_LOAD);
  assign o_ld_busy  = (state_q == ST_LOAD);
  assign o_ld_done  = (state_q == ST_DONE);
  assign o_ld_err   = err_q;
  assign o_ld_count = count_q;
  // A byte presented on the reset edge is dropped so an abort never writes.
  assign o_we       = accept && !i_rst;
  assign o_waddr    = count_q[MEM_AW-1:0];

endmodule

// File: rtl/inst_mem_loader.sv
// Big-endian byte-addressed instruction memory with registered fetch port,
// combinational debug readback and a streaming loader front end.
module inst_mem_loader
  import inst_mem_pkg::*;
#(
  parameter int NB_BYTE = 8,
  parameter int NB_INST = 32,
  parameter int DEPTH   = 1024,
  parameter int NB_ADDR = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_step,
  input  logic [NB_ADDR-1:0] i_pc,
  output logic [NB_INST-1:0] o_inst,
  output logic               o_fetch_err,
  input  logic               i_ld_start,
  input  logic [NB_ADDR-1:0] i_ld_len,
  input  logic [NB_BYTE-1:0] i_ld_byte,
  input  logic               i_ld_valid,
  output logic               o_ld_ready,
  output logic               o_ld_busy,
  output logic               o_ld_done,
  output logic               o_ld_err,
  output logic [NB_ADDR-1:0] o_ld_count,
  input  logic [NB_ADDR-1:0] i_dbg_addr,
  output logic [NB_INST-1:0] o_dbg_data
);

  localparam int N_BYTES = NB_INST / NB_BYTE;
  localparam int MEM_AW  = $clog2(DEPTH);

  logic [NB_BYTE-1:0] mem [DEPTH];
  logic               we;
  logic [MEM_AW-1:0]  waddr;
  logic [NB_INST-1:0] inst_q, inst_d;
  logic               fetch_err_q, fetch_err_d;
  logic [NB_INST-1:0] fetch_word, dbg_word;
  logic               fetch_ok, dbg_ok;
  logic [MEM_AW-1:0]  pc_idx, dbg_idx;

  inst_mem_load_fsm #(
    .NB_ADDR (NB_ADDR),
    .N_BYTES (N_BYTES),
    .DEPTH   (DEPTH),
    .MEM_AW  (MEM_AW)
  ) u_load_fsm (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_ld_start (i_ld_start),
    .i_ld_len   (i_ld_len),
    .i_ld_valid (i_ld_valid),
    .o_ld_ready (o_ld_ready),
    .o_ld_busy  (o_ld_busy),
    .o_ld_done  (o_ld_done),
    .o_ld_err   (o_ld_err),
    .o_ld_count (o_ld_count),
    .o_we       (we),
    .o_waddr    (waddr)
  );

  always_ff @(posedge i_clk) begin
    if (we) mem[waddr] <= i_ld_byte;
  end

  assign pc_idx   = i_pc[MEM_AW-1:0];
  assign dbg_idx  = i_dbg_addr[MEM_AW-1:0];
  assign fetch_ok = f_addr_ok(DEF_NB_ADDR'(i_pc), 1'b1, N_BYTES, DEPTH);
  assign dbg_ok   = f_addr_ok(DEF_NB_ADDR'(i_dbg_addr), 1'b0, N_BYTES, DEPTH);

  // Lowest address lands in the most significant byte.
  always_comb begin
    fetch_word = '0;
    dbg_word   = '0;
    for (int k = 0; k < N_BYTES; k++) begin
      fetch_word[NB_INST-1-k*NB_BYTE -: NB_BYTE] = mem[pc_idx + MEM_AW'(k)];
      dbg_word[NB_INST-1-k*NB_BYTE -: NB_BYTE]   = mem[dbg_idx + MEM_AW'(k)];
    end
  end

  assign o_dbg_data = dbg_ok ? dbg_word : NB_INST'(NOP);

  always_comb begin
    inst_d      = inst_q;
    fetch_err_d = fetch_err_q;
    if (i_step && !o_ld_busy) begin
      inst_d      = fetch_ok ? fetch_word : NB_INST'(NOP);
      fetch_err_d = !fetch_ok;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      inst_q      <= '0;
      fetch_err_q <= 1'b0;
    end else begin
      inst_q      <= inst_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  assign o_inst      = inst_q;
  assign o_fetch_err = fetch_err_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader: load, fetch, error and abort scenarios.
module tb_inst_mem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        step;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        fetch_err;
  logic        ld_start;
  logic [31:0] ld_len;
  logic [7:0]  ld_byte;
  logic        ld_valid;
  logic        ld_ready;
  logic        ld_busy;
  logic        ld_done;
  logic        ld_err;
  logic [31:0] ld_count;
  logic [31:0] dbg_addr;
  logic [31:0] dbg_data;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  inst_mem_loader dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_step      (step),
    .i_pc        (pc),
    .o_inst      (inst),
    .o_fetch_err (fetch_err),
    .i_ld_start  (ld_start),
    .i_ld_len    (ld_len),
    .i_ld_byte   (ld_byte),
    .i_ld_valid  (ld_valid),
    .o_ld_ready  (ld_ready),
    .o_ld_busy   (ld_busy),
    .o_ld_done   (ld_done),
    .o_ld_err    (ld_err),
    .o_ld_count  (ld_count),
    .i_dbg_addr  (dbg_addr),
    .o_dbg_data  (dbg_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [7:0] stream1 [8];
  logic [7:0] stream5 [4];
  logic       pat5    [7];
  logic [31:0] bad_len [3];
  int busy_cycles;
  int done_seen;
  int k;

  initial begin
    stream1 = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    stream5 = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    pat5    = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    bad_len = '{32'd6, 32'd0, 32'd1028};

    rst = 1'b1; step = 1'b0; pc = '0; ld_start = 1'b0; ld_len = '0;
    ld_byte = '0; ld_valid = 1'b0; dbg_addr = '0;
    tick(); tick();
    chk("rst_inst",  inst, 32'h0);
    chk("rst_ferr",  {31'b0, fetch_err}, 32'h0);
    chk("rst_ready", {31'b0, ld_ready}, 32'h0);
    chk("rst_busy",  {31'b0, ld_busy}, 32'h0);
    chk("rst_done",  {31'b0, ld_done}, 32'h0);
    chk("rst_lderr", {31'b0, ld_err}, 32'h0);
    chk("rst_count", ld_count, 32'h0);
    rst = 1'b0;
    tick();

    // Test 1: 8-byte back-to-back load
    ld_start = 1'b1; ld_len = 32'd8;
    tick();
    ld_start = 1'b0;
    chk("t1_ready", {31'b0, ld_ready}, 32'h1);
    chk("t1_count0", ld_count, 32'h0);
    busy_cycles = 0; done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      ld_byte = stream1[i]; ld_valid = 1'b1;
      if (ld_busy) busy_cycles++;
      if (ld_done) done_seen++;
      tick();
    end
    ld_valid = 1'b0;
    if (ld_busy) busy_cycles++;
    chk("t1_busy_cycles", busy_cycles, 32'd8);
    chk("t1_done", {31'b0, ld_done}, 32'h1);
    chk("t1_ready_off", {31'b0, ld_ready}, 32'h0);
    chk("t1_count", ld_count, 32'd8);
    tick();
    chk("t1_done_once", {31'b0, ld_done}, 32'h0);
    chk("t1_done_in_load", done_seen, 32'd0);
    chk("t1_count_hold", ld_count, 32'd8);
    dbg_addr = 32'd4; #1;
    chk("t1_dbg4", dbg_data, 32'hAABBCCDD);
    dbg_addr = 32'd0; #1;
    chk("t1_dbg0", dbg_data, 32'h12345678);
    dbg_addr = 32'd1021; #1;
    chk("t1_dbg_range", dbg_data, 32'h0);

    // Test 2: fetches
    step = 1'b1; pc = 32'd0;
    tick();
    chk("t2_inst0", inst, 32'h12345678);
    chk("t2_ferr0", {31'b0, fetch_err}, 32'h0);
    pc = 32'd4;
    tick();
    chk("t2_inst4", inst, 32'hAABBCCDD);
    step = 1'b0; pc = 32'd0;
    tick(); tick();
    chk("t2_hold", inst, 32'hAABBCCDD);

    // Test 3: fetch errors and boundaries
    step = 1'b1; pc = 32'd2;
    tick();
    chk("t3_mis_inst", inst, 32'h0);
    chk("t3_mis_err", {31'b0, fetch_err}, 32'h1);
    pc = 32'd1024;
    tick();
    chk("t3_oor_inst", inst, 32'h0);
    chk("t3_oor_err", {31'b0, fetch_err}, 32'h1);
    pc = 32'd1020;
    tick();
    chk("t3_last_ok", {31'b0, fetch_err}, 32'h0);
    pc = 32'd1021;
    tick();
    chk("t3_last_mis", {31'b0, fetch_err}, 32'h1);
    pc = 32'd0;
    tick();
    chk("t3_clear_err", {31'b0, fetch_err}, 32'h0);
    chk("t3_clear_inst", inst, 32'h12345678);
    step = 1'b0;

    // Test 4: rejected lengths
    for (int i = 0; i < 3; i++) begin
      ld_start = 1'b1; ld_len = bad_len[i];
      tick();
      ld_start = 1'b0;
      chk("t4_err_pulse", {31'b0, ld_err}, 32'h1);
      chk("t4_ready", {31'b0, ld_ready}, 32'h0);
      chk("t4_busy", {31'b0, ld_busy}, 32'h0);
      tick();
      chk("t4_err_clear", {31'b0, ld_err}, 32'h0);
      chk("t4_still_idle", {31'b0, ld_ready}, 32'h0);
    end

    // Test 5: gapped load with fetch in the start cycle and step held during LOAD
    step = 1'b1; pc = 32'd4; ld_start = 1'b1; ld_len = 32'd4;
    tick();
    ld_start = 1'b0; pc = 32'd0;
    chk("t5_start_fetch", inst, 32'hAABBCCDD);
    chk("t5_busy", {31'b0, ld_busy}, 32'h1);
    k = 0;
    for (int i = 0; i < 7; i++) begin
      ld_valid = pat5[i];
      ld_byte  = pat5[i] ? stream5[k] : 8'h55;
      tick();
      if (pat5[i]) k++;
      if (k < 4) chk("t5_count", ld_count, k);
    end
    ld_valid = 1'b0;
    chk("t5_done", {31'b0, ld_done}, 32'h1);
    chk("t5_count_final", ld_count, 32'd4);
    chk("t5_inst_held", inst, 32'hAABBCCDD);
    step = 1'b0;
    tick();
    chk("t5_done_off", {31'b0, ld_done}, 32'h0);
    dbg_addr = 32'd0; #1;
    chk("t5_dbg0", dbg_data, 32'hDEADBEEF);
    dbg_addr = 32'd4; #1;
    chk("t5_dbg4", dbg_data, 32'hAABBCCDD);

    // Test 6: reset mid-load
    ld_start = 1'b1; ld_len = 32'd4;
    tick();
    ld_start = 1'b0;
    ld_valid = 1'b1; ld_byte = 8'h11;
    tick();
    ld_byte = 8'h22;
    tick();
    ld_valid = 1'b0; rst = 1'b1;
    tick();
    chk("t6_busy", {31'b0, ld_busy}, 32'h0);
    chk("t6_ready", {31'b0, ld_ready}, 32'h0);
    chk("t6_done", {31'b0, ld_done}, 32'h0);
    chk("t6_count", ld_count, 32'h0);
    chk("t6_inst", inst, 32'h0);
    rst = 1'b0;
    tick();
    chk("t6_no_done", {31'b0, ld_done}, 32'h0);
    chk("t6_idle", {31'b0, ld_busy}, 32'h0);
    dbg_addr = 32'd0; #1;
    chk("t6_dbg0", dbg_data, 32'h1122BEEF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
